// File: rtl/of_header_parser_if.sv
// rtl/of_header_parser_if.sv - datapath tap and parsed-header bus for of_header_parser
`ifndef OF_HEADER_REG_WIDTH
`define OF_HEADER_REG_WIDTH 236
`endif

interface of_header_parser_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]           in_data;
  logic [CTRL_WIDTH-1:0]           in_ctrl;
  logic                            in_wr;
  logic [`OF_HEADER_REG_WIDTH-1:0] header_bus;
  logic                            headers_valid;
  logic [31:0]                     num_pkts_parsed;

  // master drives the observed datapath and consumes parsed headers
  modport master (
    output in_data, in_ctrl, in_wr,
    input  header_bus, headers_valid, num_pkts_parsed
  );

  // slave is the parser itself
  modport slave (
    input  in_data, in_ctrl, in_wr,
    output header_bus, headers_valid, num_pkts_parsed
  );
endinterface

// File: rtl/of_header_parser.sv
// rtl/of_header_parser.sv - passive OpenFlow header parser; OF_PARSER_VLAN_EN enables 802.1Q tag parsing
`ifndef OF_HEADER_REG_WIDTH
`define OF_HEADER_REG_WIDTH 236
`endif

module of_header_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  of_header_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MOD_HDR, PKT, WAIT_EOP} state_e;

  localparam int BPW    = DATA_WIDTH / 8;   // bytes per datapath word
  localparam int NBYTES = 6 * BPW;          // words 0..5 hold every parsed field
  localparam int HW     = `OF_HEADER_REG_WIDTH;

  state_e        state_q;
  logic [2:0]    wcnt_q;
  logic [7:0]    in_port_q;
  logic [7:0]    buf_q [NBYTES];
  logic [HW-1:0] header_bus_q;
  logic          headers_valid_q;
  logic [31:0]   num_pkts_q;

  logic          ctrl_zero;
  logic          start_pkt;
  logic          cap_pkt;
  logic          hit_eop;
  logic          fire;
  logic [2:0]    cap_idx;
  logic [7:0]    mb_d [NBYTES];

  logic [15:0]   eth_type_d;
  logic [15:0]   dl_type_d;
  logic [11:0]   vlan_d;
  logic [5:0]    l3_d;
  logic          is_ip_d;
  logic          has_tp_d;
  logic [7:0]    proto_d;
  logic [31:0]   nw_src_d;
  logic [31:0]   nw_dst_d;
  logic [15:0]   tp_src_d;
  logic [15:0]   tp_dst_d;

  // classify the current datapath beat against the parser state
  always_comb begin
    ctrl_zero = (bus.in_ctrl == '0);
    start_pkt = ((state_q == IDLE) || (state_q == MOD_HDR)) && bus.in_wr && ctrl_zero;
    cap_pkt   = (state_q == PKT) && bus.in_wr;
    hit_eop   = cap_pkt && !ctrl_zero;
    fire      = cap_pkt && ((wcnt_q == 3'd5) || !ctrl_zero);
    cap_idx   = start_pkt ? 3'd0 : wcnt_q;
  end

  // byte image of the packet so far with the incoming word merged in; a new packet starts from zeros
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      mb_d[i] = start_pkt ? 8'h00 : buf_q[i];
      if ((start_pkt || cap_pkt) && (int'(cap_idx) == i / BPW))
        mb_d[i] = bus.in_data[DATA_WIDTH-1-8*(i%BPW) -: 8];
    end
  end

  // decode flow fields from the merged byte image
  always_comb begin
    eth_type_d = {mb_d[12], mb_d[13]};
`ifdef OF_PARSER_VLAN_EN
    if (eth_type_d == 16'h8100) begin
      vlan_d    = {mb_d[14][3:0], mb_d[15]};
      dl_type_d = {mb_d[16], mb_d[17]};
      l3_d      = 6'd18;
    end else begin
      vlan_d    = 12'hFFF;
      dl_type_d = eth_type_d;
      l3_d      = 6'd14;
    end
`else
    vlan_d    = 12'hFFF;
    dl_type_d = eth_type_d;
    l3_d      = 6'd14;
`endif
    is_ip_d  = (dl_type_d == 16'h0800);
    proto_d  = is_ip_d ? mb_d[l3_d + 6'd9] : 8'h00;
    nw_src_d = is_ip_d ? {mb_d[l3_d + 6'd12], mb_d[l3_d + 6'd13],
                          mb_d[l3_d + 6'd14], mb_d[l3_d + 6'd15]} : 32'h0;
    nw_dst_d = is_ip_d ? {mb_d[l3_d + 6'd16], mb_d[l3_d + 6'd17],
                          mb_d[l3_d + 6'd18], mb_d[l3_d + 6'd19]} : 32'h0;
    // transport ports sit at a fixed offset only when there are no IP options
    has_tp_d = is_ip_d && (mb_d[l3_d][3:0] == 4'd5) &&
               ((proto_d == 8'd6) || (proto_d == 8'd17));
    tp_src_d = has_tp_d ? {mb_d[l3_d + 6'd20], mb_d[l3_d + 6'd21]} : 16'h0;
    tp_dst_d = has_tp_d ? {mb_d[l3_d + 6'd22], mb_d[l3_d + 6'd23]} : 16'h0;
  end

  // hold captured packet bytes between beats; cleared on entry to PKT through mb_d
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) buf_q[i] <= 8'h00;
    end else if (start_pkt || cap_pkt) begin
      for (int i = 0; i < NBYTES; i++) buf_q[i] <= mb_d[i];
    end
  end

  // parser FSM with registered header bus, valid pulse and packet counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wcnt_q          <= 3'd0;
      in_port_q       <= 8'h00;
      header_bus_q    <= '0;
      headers_valid_q <= 1'b0;
      num_pkts_q      <= 32'h0;
    end else begin
      headers_valid_q <= 1'b0;
      case (state_q)
        IDLE, MOD_HDR: begin
          if (bus.in_wr) begin
            if (ctrl_zero) begin
              state_q <= PKT;
              wcnt_q  <= 3'd1;
            end else if (bus.in_ctrl == CTRL_WIDTH'(8'hFF)) begin
              in_port_q <= bus.in_data[23:16];
              state_q   <= MOD_HDR;
            end
          end
        end
        PKT: begin
          if (bus.in_wr) begin
            wcnt_q <= wcnt_q + 3'd1;
            if (fire) begin
              headers_valid_q <= 1'b1;
              header_bus_q    <= {in_port_q,
                                  mb_d[0], mb_d[1], mb_d[2], mb_d[3], mb_d[4], mb_d[5],
                                  mb_d[6], mb_d[7], mb_d[8], mb_d[9], mb_d[10], mb_d[11],
                                  vlan_d, dl_type_d, nw_src_d, nw_dst_d, proto_d,
                                  tp_src_d, tp_dst_d};
              num_pkts_q      <= num_pkts_q + 32'd1;
              // the next packet carries its own module header, if any
              in_port_q       <= 8'h00;
              state_q         <= hit_eop ? IDLE : WAIT_EOP;
            end
          end
        end
        WAIT_EOP: begin
          if (bus.in_wr && !ctrl_zero) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.header_bus      = header_bus_q;
  assign bus.headers_valid   = headers_valid_q;
  assign bus.num_pkts_parsed = num_pkts_q;

endmodule

// File: tb/tb_of_header_parser.sv
// tb/tb_of_header_parser.sv - randomized self-checking bench for of_header_parser
module tb_of_header_parser;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  of_header_parser_if bus ();
  of_header_parser dut (.clk(clk), .reset(reset), .bus(bus));

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [7:0]   pkt [64];
  logic [7:0]   exp_inport;
  logic [31:0]  exp_count;
  logic [235:0] last_hdr;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // byte i as the parser may see it: only words 0..5 and nothing past the end
  function automatic logic [7:0] pb(input int i, input int nw);
    int lim;
    lim = 8 * ((nw < 6) ? nw : 6);
    return (i < lim) ? pkt[i] : 8'h00;
  endfunction

  function automatic logic [63:0] word_of(input int k);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[63-8*b -: 8] = pkt[8*k+b];
    return w;
  endfunction

  // reference: flow fields from the packet bytes by the protocol rules
  function automatic logic [235:0] model(input int nw, input logic [7:0] port);
    logic [15:0] et, typ, ts, td;
    logic [11:0] vid;
    logic [7:0]  pr, ihlb;
    logic [31:0] s, d;
    int          l3;
    et = {pb(12, nw), pb(13, nw)};
    vid = 12'hFFF; typ = et; l3 = 14;
`ifdef OF_PARSER_VLAN_EN
    if (et == 16'h8100) begin
      vid = 12'({pb(14, nw), pb(15, nw)});
      typ = {pb(16, nw), pb(17, nw)};
      l3  = 18;
    end
`endif
    pr = 0; s = 0; d = 0; ts = 0; td = 0;
    if (typ == 16'h0800) begin
      pr   = pb(l3 + 9, nw);
      s    = {pb(l3 + 12, nw), pb(l3 + 13, nw), pb(l3 + 14, nw), pb(l3 + 15, nw)};
      d    = {pb(l3 + 16, nw), pb(l3 + 17, nw), pb(l3 + 18, nw), pb(l3 + 19, nw)};
      ihlb = pb(l3, nw);
      if (ihlb[3:0] == 4'd5 && (pr == 8'd6 || pr == 8'd17)) begin
        ts = {pb(l3 + 20, nw), pb(l3 + 21, nw)};
        td = {pb(l3 + 22, nw), pb(l3 + 23, nw)};
      end
    end
    return {port,
            pb(0, nw), pb(1, nw), pb(2, nw), pb(3, nw), pb(4, nw), pb(5, nw),
            pb(6, nw), pb(7, nw), pb(8, nw), pb(9, nw), pb(10, nw), pb(11, nw),
            vid, typ, s, d, pr, ts, td};
  endfunction

  // kinds: 0 TCP, 1 UDP, 2 ICMP, 3 TCP IHL=6, 4 ARP, 5 VLAN UDP, 6 VLAN TCP, 7 VLAN ARP
  task automatic build(input int kind, input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] tci);
    int l3, ihl;
    logic [7:0] proto;
    bit vlan, ip;
    for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
    vlan = (kind >= 5);
    ip   = (kind != 4) && (kind != 7);
    ihl  = (kind == 3) ? 6 : 5;
    case (kind)
      0, 3, 6: proto = 8'd6;
      1, 5:    proto = 8'd17;
      default: proto = 8'd1;
    endcase
    l3 = 14;
    if (vlan) begin
      pkt[12] = 8'h81; pkt[13] = 8'h00;
      pkt[14] = tci[15:8]; pkt[15] = tci[7:0];
      l3 = 18;
    end
    pkt[l3-2] = 8'h08;
    pkt[l3-1] = ip ? 8'h00 : 8'h06;
    if (ip) begin
      pkt[l3]   = 8'(8'h40 | ihl);
      pkt[l3+9] = proto;
      for (int b = 0; b < 4; b++) begin
        pkt[l3+12+b] = src[31-8*b -: 8];
        pkt[l3+16+b] = dst[31-8*b -: 8];
      end
      pkt[l3+4*ihl]   = sp[15:8]; pkt[l3+4*ihl+1] = sp[7:0];
      pkt[l3+4*ihl+2] = dp[15:8]; pkt[l3+4*ihl+3] = dp[7:0];
    end
  endtask

  task automatic step(input logic wr, input logic [63:0] data, input logic [7:0] ctrl, input bit exp_hv);
    bus.in_wr = wr; bus.in_data = data; bus.in_ctrl = ctrl;
    @(negedge clk);
    check("headers_valid", 256'(bus.headers_valid), 256'(exp_hv));
  endtask

  task automatic send_mod(input logic [7:0] port);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[23:16] = port;
    step(1'b1, d, 8'hFF, 1'b0);
    exp_inport = port;
  endtask

  task automatic send_ign();
    step(1'b1, {$urandom, $urandom}, 8'($urandom_range(1, 254)), 1'b0);
  endtask

  task automatic send_packet(input int nw, input bit gaps);
    int pidx;
    logic [235:0] eh;
    check("header_hold", 256'(bus.header_bus), 256'(last_hdr));
    pidx = (nw - 1 < 5) ? nw - 1 : 5;
    eh = model(nw, exp_inport);
    for (int k = 0; k < nw; k++) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          step(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0);
      end
      step(1'b1, word_of(k), (k == nw - 1) ? 8'h80 : 8'h00, k == pidx);
      if (k == pidx) begin
        exp_count++;
        check("header_bus", 256'(bus.header_bus), 256'(eh));
        check("num_pkts_parsed", 256'(bus.num_pkts_parsed), 256'(exp_count));
        last_hdr = eh;
      end
    end
    exp_inport = 8'h00;
    bus.in_wr = 1'b0;
  endtask

  logic [235:0] gapless_hdr;

  initial begin
    exp_inport = 0; exp_count = 0; last_hdr = 0;
    reset = 1'b1; bus.in_wr = 1'b0; bus.in_data = '0; bus.in_ctrl = '0;
    repeat (3) @(negedge clk);
    check("rst_headers_valid", 256'(bus.headers_valid), 256'(0));
    check("rst_header_bus", 256'(bus.header_bus), 256'(0));
    check("rst_count", 256'(bus.num_pkts_parsed), 256'(0));
    reset = 1'b0;

    // untagged TCP with module header
    send_mod(8'h02);
    build(0, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80, 16'h0);
    send_packet(8, 1'b0);
    check("tcp_in_port", 256'(bus.header_bus[235:228]), 256'(8'h02));
    check("tcp_vlan", 256'(bus.header_bus[131:120]), 256'(12'hFFF));
    check("tcp_type", 256'(bus.header_bus[119:104]), 256'(16'h0800));
    check("tcp_nw_src", 256'(bus.header_bus[103:72]), 256'(32'h0a000001));
    check("tcp_nw_dst", 256'(bus.header_bus[71:40]), 256'(32'h0a000002));
    check("tcp_proto", 256'(bus.header_bus[39:32]), 256'(8'd6));
    check("tcp_tp_src", 256'(bus.header_bus[31:16]), 256'(16'd1234));
    check("tcp_tp_dst", 256'(bus.header_bus[15:0]), 256'(16'd80));
    check("tcp_count", 256'(bus.num_pkts_parsed), 256'(1));

    // 802.1Q tagged UDP
    build(5, 32'hc0a80001, 32'hc0a80002, 16'd53, 16'd53, 16'h0064);
    send_packet(8, 1'b0);
`ifdef OF_PARSER_VLAN_EN
    check("vlan_id", 256'(bus.header_bus[131:120]), 256'(12'h064));
    check("vlan_type", 256'(bus.header_bus[119:104]), 256'(16'h0800));
    check("vlan_tp", 256'(bus.header_bus[31:0]), 256'({16'd53, 16'd53}));
`else
    check("vlan_id", 256'(bus.header_bus[131:120]), 256'(12'hFFF));
    check("vlan_type", 256'(bus.header_bus[119:104]), 256'(16'h8100));
    check("vlan_l3", 256'(bus.header_bus[103:0]), 256'(0));
`endif

    // ARP, 4 words: pulse follows the EOP word
    build(4, 0, 0, 0, 0, 0);
    send_packet(4, 1'b0);
    check("arp_l3", 256'(bus.header_bus[103:0]), 256'(0));

    // IPv4 with options, and ICMP: no transport ports
    build(3, 32'h01020304, 32'h05060708, 16'd7, 16'd9, 0);
    send_packet(8, 1'b0);
    check("ihl6_tp", 256'(bus.header_bus[31:0]), 256'(0));
    check("ihl6_nw_src", 256'(bus.header_bus[103:72]), 256'(32'h01020304));
    build(2, 32'h0b0b0b0b, 32'h0c0c0c0c, 16'd7, 16'd9, 0);
    send_packet(6, 1'b0);
    check("icmp_tp", 256'(bus.header_bus[31:0]), 256'(0));
    check("icmp_proto", 256'(bus.header_bus[39:32]), 256'(8'd1));

    // reset at data word 2 aborts the packet
    send_mod(8'h33);
    build(0, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    step(1'b1, word_of(0), 8'h00, 1'b0);
    step(1'b1, word_of(1), 8'h00, 1'b0);
    bus.in_wr = 1'b1; bus.in_data = word_of(2); bus.in_ctrl = 8'h00; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_headers_valid", 256'(bus.headers_valid), 256'(0));
    check("rstmid_count", 256'(bus.num_pkts_parsed), 256'(0));
    check("rstmid_header_bus", 256'(bus.header_bus), 256'(0));
    exp_count = 0; last_hdr = 0; exp_inport = 0;
    step(1'b1, word_of(3), 8'h80, 1'b0);
    build(1, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    send_packet(7, 1'b0);
    check("rstmid_in_port", 256'(bus.header_bus[235:228]), 256'(0));

    // in_wr gaps inside a packet must not change the result
    build(6, $urandom, $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
    send_packet(8, 1'b0);
    gapless_hdr = bus.header_bus;
    send_packet(8, 1'b1);
    check("gap_vs_gapless", 256'(bus.header_bus), 256'(gapless_hdr));

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      for (int m = $urandom_range(0, 2); m > 0; m--) begin
        if ($urandom_range(0, 2) == 0) send_ign();
        else send_mod(8'($urandom));
      end
      build($urandom_range(0, 7), $urandom, $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
      send_packet($urandom_range(2, 8), 1'($urandom));
      repeat ($urandom_range(0, 2)) step(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0);
    end

    // counter wrap
    force dut.num_pkts_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.num_pkts_q;
    exp_count = 32'hFFFF_FFFF;
    build(0, $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    send_packet(3, 1'b0);
    check("count_wrap", 256'(bus.num_pkts_parsed), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
